// File: rtl/wb_pipe_slave.sv
`default_nettype none
// ============================================================================
// Module  : wb_pipe_slave
// Brief   : Pipelined Wishbone B4 responder with an in-order request FIFO,
//           a word-addressed register bank and a programmable service gap.
// Revision: 1.0
// ============================================================================
module wb_pipe_slave #(
    parameter int MEM_WORDS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SVC_GAP    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wb_cyc,
    input  logic                          i_wb_stb,
    input  logic                          i_wb_we,
    input  logic [31:0]                   i_wb_addr,
    input  logic [31:0]                   i_wb_data,
    output logic [31:0]                   o_wb_data,
    output logic                          o_wb_ack,
    output logic                          o_wb_stall,
    output logic [$clog2(FIFO_DEPTH):0]   o_pending
);

    localparam int c_AW = $clog2(MEM_WORDS);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_GW = (SVC_GAP < 2) ? 1 : $clog2(SVC_GAP + 1);

    localparam logic [c_PW:0]   c_FULL    = (c_PW + 1)'(FIFO_DEPTH);
    localparam logic [c_PW:0]   c_CNT_ONE = (c_PW + 1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_GW-1:0] c_GAP     = c_GW'(SVC_GAP);
    localparam logic [c_GW-1:0] c_GAP_ONE = c_GW'(1);

    logic [31:0]     r_bank      [MEM_WORDS];
    logic            r_fifo_we   [FIFO_DEPTH];
    logic [c_AW-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic [31:0]     r_fifo_data [FIFO_DEPTH];

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;
    logic [c_GW-1:0] r_gap;
    logic            r_ack;
    logic [31:0]     r_rdata;

    logic            w_push;
    logic            w_pop;
    logic            w_head_we;
    logic [c_AW-1:0] w_head_idx;
    logic [31:0]     w_head_data;
    logic            w_unused_addr;

    assign o_wb_stall    = (r_count == c_FULL);
    assign o_pending     = r_count;
    assign o_wb_ack      = r_ack;
    assign o_wb_data     = r_rdata;

    assign w_push        = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign w_pop         = i_wb_cyc & (r_count != '0) & (r_gap == '0);

    assign w_head_we     = r_fifo_we[r_rd_ptr];
    assign w_head_idx    = r_fifo_idx[r_rd_ptr];
    assign w_head_data   = r_fifo_data[r_rd_ptr];

    // Byte offset and upper address bits only cause aliasing.
    assign w_unused_addr = ^{i_wb_addr[31:c_AW+2], i_wb_addr[1:0]};

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]   <= i_wb_we;
            r_fifo_idx[r_wr_ptr]  <= i_wb_addr[c_AW+1:2];
            r_fifo_data[r_wr_ptr] <= i_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_gap    <= '0;
            r_ack    <= 1'b0;
        end else if (!i_wb_cyc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_gap    <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_gap <= c_GAP;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GAP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_bank[i] <= '0;
            end
            r_rdata <= '0;
        end else if (w_pop) begin
            if (w_head_we) begin
                r_bank[w_head_idx] <= w_head_data;
            end else begin
                r_rdata <= r_bank[w_head_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_pipe_slave
// Brief   : Directed self-checking bench; one instance with no service gap,
//           one with SVC_GAP=3 for back-pressure and abort scenarios.
// Revision: 1.0
// ============================================================================
module tb_wb_pipe_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;

    logic        w_cyc0;
    logic        w_cyc1;
    logic [31:0] w_rdata0;
    logic [31:0] w_rdata1;
    logic        w_ack0;
    logic        w_ack1;
    logic        w_stall0;
    logic        w_stall1;
    logic [2:0]  w_pend0;
    logic [2:0]  w_pend1;

    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic [2:0]  pend;

    int          n_pass  = 0;
    int          n_total = 0;

    int          ack_cnt;
    int          acc_cnt;
    int          max_pend;
    logic        stall_seen;
    int          ack_t [16];
    logic [31:0] ack_d [16];

    always #5 clk = ~clk;

    assign w_cyc0 = cyc & ~sel;
    assign w_cyc1 = cyc & sel;
    assign rdata  = sel ? w_rdata1 : w_rdata0;
    assign ack    = sel ? w_ack1   : w_ack0;
    assign stall  = sel ? w_stall1 : w_stall0;
    assign pend   = sel ? w_pend1  : w_pend0;

    wb_pipe_slave #(.MEM_WORDS(16), .FIFO_DEPTH(4), .SVC_GAP(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .i_wb_cyc   (w_cyc0),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .o_wb_data  (w_rdata0),
        .o_wb_ack   (w_ack0),
        .o_wb_stall (w_stall0),
        .o_pending  (w_pend0)
    );

    wb_pipe_slave #(.MEM_WORDS(16), .FIFO_DEPTH(4), .SVC_GAP(3)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .i_wb_cyc   (w_cyc1),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .o_wb_data  (w_rdata1),
        .o_wb_ack   (w_ack1),
        .o_wb_stall (w_stall1),
        .o_pending  (w_pend1)
    );

    // Streams n requests honouring stall; edge 0 is the first edge after entry.
    task automatic stream(input logic we_i, input int n,
                          input logic [31:0] addr0, input logic [31:0] data0);
        int   next;
        int   e;
        logic acc;
        next       = 0;
        e          = 0;
        ack_cnt    = 0;
        acc_cnt    = 0;
        max_pend   = 0;
        stall_seen = 1'b0;
        cyc        = 1'b1;
        while (ack_cnt < n && e < 200) begin
            if (next < n) begin
                stb   = 1'b1;
                we    = we_i;
                addr  = addr0 + 32'(4 * next);
                wdata = data0 + 32'(next);
            end else begin
                stb = 1'b0;
            end
            #1;
            acc = stb && !stall;
            if (stall) stall_seen = 1'b1;
            @(posedge clk);
            #1;
            if (acc) begin
                next++;
                acc_cnt++;
            end
            if (int'(pend) > max_pend) max_pend = int'(pend);
            if (ack) begin
                if (ack_cnt < 16) begin
                    ack_t[ack_cnt] = e;
                    ack_d[ack_cnt] = rdata;
                end
                ack_cnt++;
            end
            e++;
        end
        stb = 1'b0;
    endtask

    task automatic idle_check(input string name);
        @(posedge clk);
        #1;
        n_total++;
        if (ack !== 1'b0) $display("FAIL %s: extra ack, got %b want 0", name, ack);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({ack, stall, pend, rdata} !== 37'd0)
            $display("FAIL reset: ack=%b stall=%b pend=%0d data=%h want all 0", ack, stall, pend, rdata);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single;
        sel = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        stb = 1'b0;
        n_total++;
        if (ack !== 1'b0 || pend !== 3'd1) $display("FAIL single_accept: ack=%b pend=%0d want 0/1", ack, pend);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ack !== 1'b1 || pend !== 3'd0) $display("FAIL single_wr_ack: ack=%b pend=%0d want 1/0", ack, pend);
        else n_pass++;
        stb = 1'b1; we = 1'b0; addr = 32'h08; wdata = '0;
        @(posedge clk); #1;
        stb = 1'b0;
        n_total++;
        if (ack !== 1'b0) $display("FAIL single_rd_early: ack=%b want 0", ack);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ack !== 1'b1 || rdata !== 32'hDEADBEEF)
            $display("FAIL single_rd: ack=%b data=%h want 1/deadbeef", ack, rdata);
        else n_pass++;
        idle_check("single_idle");
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        stream(1'b1, 8, 32'h00, 32'h100);
        n_total++;
        if (ack_cnt !== 8 || stall_seen !== 1'b0)
            $display("FAIL b2b_wr: acks=%0d stall_seen=%b want 8/0", ack_cnt, stall_seen);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (ack_t[j] !== j + 1) $display("FAIL b2b_wr_time[%0d]: got %0d want %0d", j, ack_t[j], j + 1);
            else n_pass++;
        end
        idle_check("b2b_wr_idle");
        stream(1'b0, 8, 32'h00, 32'h0);
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (ack_t[j] !== j + 1 || ack_d[j] !== 32'h100 + 32'(j))
                $display("FAIL b2b_rd[%0d]: t=%0d data=%h want %0d/%h", j, ack_t[j], ack_d[j], j + 1, 32'h100 + 32'(j));
            else n_pass++;
        end
        idle_check("b2b_rd_idle");
    endtask

    task automatic test_aliasing;
        sel = 1'b0;
        stream(1'b1, 1, 32'h40, 32'h5A5A5A5A);
        stream(1'b0, 1, 32'h00, 32'h0);
        n_total++;
        if (ack_cnt !== 1 || ack_d[0] !== 32'h5A5A5A5A) $display("FAIL alias_00: data=%h want 5a5a5a5a", ack_d[0]);
        else n_pass++;
        stream(1'b0, 1, 32'h43, 32'h0);
        n_total++;
        if (ack_cnt !== 1 || ack_d[0] !== 32'h5A5A5A5A) $display("FAIL alias_43: data=%h want 5a5a5a5a", ack_d[0]);
        else n_pass++;
        idle_check("alias_idle");
    endtask

    task automatic test_backpressure;
        sel = 1'b1;
        stream(1'b1, 8, 32'h20, 32'h200);
        n_total++;
        if (ack_cnt !== 8 || acc_cnt !== 8 || max_pend !== 4 || stall_seen !== 1'b1)
            $display("FAIL bp_wr: acks=%0d acc=%0d max_pend=%0d stall=%b want 8/8/4/1", ack_cnt, acc_cnt, max_pend, stall_seen);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (ack_t[j] !== 1 + 4 * j) $display("FAIL bp_time[%0d]: got %0d want %0d", j, ack_t[j], 1 + 4 * j);
            else n_pass++;
        end
        idle_check("bp_idle");
        cyc = 1'b0;
        @(posedge clk); #1;
        stream(1'b0, 8, 32'h20, 32'h0);
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (ack_d[j] !== 32'h200 + 32'(j)) $display("FAIL bp_rd[%0d]: got %h want %h", j, ack_d[j], 32'h200 + 32'(j));
            else n_pass++;
        end
        cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        sel = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'hA;
        @(posedge clk); #1;
        addr = 32'h4; wdata = 32'hB;
        @(posedge clk); #1;
        n_total++;
        if (ack !== 1'b1) $display("FAIL abort_first_ack: got %b want 1", ack);
        else n_pass++;
        addr = 32'h8; wdata = 32'hC;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (ack !== 1'b0 || pend !== 3'd0) $display("FAIL abort_flush: ack=%b pend=%0d want 0/0", ack, pend);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ack !== 1'b0) $display("FAIL abort_no_ack: got %b want 0", ack);
        else n_pass++;
        stream(1'b0, 3, 32'h0, 32'h0);
        n_total++;
        if (ack_cnt !== 3 || ack_d[0] !== 32'hA || ack_d[1] !== 32'h0 || ack_d[2] !== 32'h0)
            $display("FAIL abort_readback: n=%0d %h %h %h want 3 a 0 0", ack_cnt, ack_d[0], ack_d[1], ack_d[2]);
        else n_pass++;
        cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        sel = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h1;
        @(posedge clk); #1;
        addr = 32'h4; wdata = 32'h2;
        @(posedge clk); #1;
        addr = 32'h8; wdata = 32'h3;
        @(posedge clk); #1;
        stb = 1'b0;
        n_total++;
        if (pend !== 3'd2) $display("FAIL rst_mid_pending: got %0d want 2", pend);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({ack, stall, pend, rdata} !== 37'd0)
            $display("FAIL rst_mid: ack=%b stall=%b pend=%0d data=%h want all 0", ack, stall, pend, rdata);
        else n_pass++;
        stream(1'b0, 1, 32'h0, 32'h0);
        n_total++;
        if (ack_cnt !== 1 || ack_d[0] !== 32'h0) $display("FAIL rst_mid_rd1: data=%h want 0", ack_d[0]);
        else n_pass++;
        cyc = 1'b0;
        sel = 1'b0;
        @(posedge clk); #1;
        stream(1'b0, 1, 32'h08, 32'h0);
        n_total++;
        if (ack_cnt !== 1 || ack_d[0] !== 32'h0) $display("FAIL rst_mid_rd0: data=%h want 0", ack_d[0]);
        else n_pass++;
        cyc = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_aliasing;
        test_backpressure;
        test_abort;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_pipe_slave.md
Name: wb_pipe_slave

Overview:
- Pipelined Wishbone (B4, stall-capable) responder: the target-side counterpart to the team's WbMaster bus initiator.
- Accepts single or back-to-back requests into a small request FIFO, services them in order against an internal word-addressed register bank, and returns one ack per accepted request.
- Asserts stall when the FIFO is full. A programmable service gap forces back-pressure for bench and integration testing of the master.

Parameters:
- MEM_WORDS, 16, number of 32-bit words in the register bank; power of 2, at least 2.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.
- SVC_GAP, 0, idle cycles inserted after each serviced request (0 = one service per cycle).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  32  byte address.
- i_wb_data  in  32  write data.
- o_wb_data  out  32  read data, valid when o_wb_ack=1.
- o_wb_ack  out  1  one-cycle completion pulse per accepted request.
- o_wb_stall  out  1  request not accepted this cycle.
- o_pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy (status/debug).

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst), and has priority over everything.
- Reset values: o_wb_ack=0, o_wb_data=0, o_pending=0, o_wb_stall=0. FIFO pointers, gap counter and every bank word are cleared to 0.
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_stall. On accept, {we, word index, data} is pushed at that clock edge.
- Word index: i_wb_addr[$clog2(MEM_WORDS)+1:2]. Bits [1:0] and the upper bits are ignored, so addresses alias modulo 4*MEM_WORDS.
- o_wb_stall is combinational: (o_pending == FIFO_DEPTH). It is not gated by cyc.
- Service (pop) condition: i_wb_cyc & FIFO non-empty & gap counter == 0.
- On pop, the head entry is executed at that edge:
  - Write: bank[idx] <= data.
  - Read: o_wb_data <= bank[idx].
- o_wb_ack is registered and equals the pop condition of the previous cycle.
- For a write ack, o_wb_data holds its previous value; it is don't-care.
- Gap counter:
  - Loaded with SVC_GAP on each pop.
  - Otherwise decrements to 0 and saturates there.
  - SVC_GAP=0 means it is always 0.
- Latency: with the FIFO empty and gap=0, a request accepted at edge N is popped at edge N+1. Ack is high in the cycle after edge N+1, i.e. 2 cycles after the accept cycle.
- Ordering: strictly FIFO. Acks come in request order and there is exactly one ack per accepted request while cyc stays high.
- Push and pop in the same cycle: occupancy unchanged and pointers both advance. Pointers wrap modulo FIFO_DEPTH.
- Read-after-write to the same word in the queue: the read returns the written value, because execution is in order.
- i_wb_cyc=0 (abort), on the next edge:
  - FIFO flushed: pointers and count go to 0.
  - Gap counter goes to 0.
  - No pop, so o_wb_ack=0 in the following cycle.
  - Queued, unserviced writes are discarded and the bank is not modified by them.
- Stb without cyc is ignored.
- rst mid-transaction behaves like an abort and additionally clears the bank and o_wb_data.

Test Plan:
1. Single access: write addr 0x08, data 0xDEADBEEF, accepted at cycle 0 -> ack at cycle 2. Then read 0x08 -> ack 2 cycles after its accept with o_wb_data=0xDEADBEEF.
2. Back-to-back streaming, SVC_GAP=0: 8 consecutive writes (addr 0x00..0x1C, data 0x100+i), stb high every cycle -> stall never asserted, 8 consecutive acks at cycles 2..9. Read-back of all 8 returns 0x100..0x107 in order.
3. Back-pressure, SVC_GAP=3, FIFO_DEPTH=4: 8 back-to-back writes -> o_pending reaches 4 and stall rises. Exactly 8 acks spaced 4 cycles apart, and no request is lost or duplicated.
4. Abort: SVC_GAP=3, push 3 writes to 0x0/0x4/0x8 (data 0xA/0xB/0xC), drop cyc after the first ack -> no further acks, o_pending=0 next cycle. Read-back gives 0x0=0xA, 0x4=0, 0x8=0.
5. Aliasing (MEM_WORDS=16): write 0x40 with data 0x5A5A5A5A, then read 0x00 -> returns 0x5A5A5A5A. Read 0x43 also returns 0x5A5A5A5A.
6. Reset mid-burst: rst for 1 cycle with 2 requests pending -> o_wb_ack=0, o_pending=0, stall=0 next cycle. Any subsequent read returns 0.
